// File: rtl/video_cmd_controller.sv
// -----------------------------------------------------------------------------
// video_cmd_controller
//
// Configuration controller sitting between the UART receive path and the video
// pipeline. Framed write commands (SYNC, ADDR, DATA, CHK) are parsed out of the
// received byte stream into four staged configuration registers. Staged values
// reach the active outputs only on the frame (vblank) strobe, so the pattern
// generator never sees a mid-frame change. Every complete command produces one
// ACK or NAK byte on the TX handshake.
//
// Ports
//   i_clk           system clock
//   i_reset         asynchronous, active-high reset
//   i_rx_byte       received byte, qualified by i_rx_valid
//   i_rx_valid      one-cycle strobe, new byte on i_rx_byte
//   i_frame_strobe  one-cycle pulse at vblank; commit point for staged regs
//   o_tx_byte       response byte, stable while o_tx_valid is high
//   o_tx_valid      response available; held until i_tx_ready
//   i_tx_ready      TX side takes o_tx_byte this cycle when o_tx_valid is high
//   o_cfg_pattern   active reg 0 (pattern select in [3:0])
//   o_cfg_fg        active reg 1 (foreground RGB332)
//   o_cfg_bg        active reg 2 (background RGB332)
//   o_cfg_ctrl      active reg 3 (misc control)
//   o_pending       per-register flag: staged value not yet committed
//   o_err_count     saturating count of NAKs, timeouts and dropped bytes
// -----------------------------------------------------------------------------
module video_cmd_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 25000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  input  logic       i_frame_strobe,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [7:0] o_cfg_pattern,
  output logic [7:0] o_cfg_fg,
  output logic [7:0] o_cfg_bg,
  output logic [7:0] o_cfg_ctrl,
  output logic [3:0] o_pending,
  output logic [7:0] o_err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_RESP
  } state_t;

  state_t         state, state_next;
  logic [7:0]     addr_q, data_q;
  logic [TW-1:0]  tmo_cnt;
  logic [7:0]     staged [4];
  logic [7:0]     active [4];
  logic [3:0]     pending;
  logic [7:0]     tx_byte;
  logic [7:0]     err_count;

  logic           chk_ok;
  logic           tmo_hit;
  logic           cmd_ok;
  logic           cmd_bad;
  logic           drop;
  logic           timeout;
  logic           err_evt;
  logic [1:0]     wr_idx;

  // The full 8-bit address is kept so out-of-range addresses can be rejected.
  assign chk_ok  = (i_rx_byte == (addr_q ^ data_q)) && (addr_q <= 8'd3);
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign wr_idx  = addr_q[1:0];

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    state_next = state;
    cmd_ok     = 1'b0;
    cmd_bad    = 1'b0;
    drop       = 1'b0;
    timeout    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_byte == SYNC_BYTE)) state_next = S_ADDR;
      end

      S_ADDR: begin
        // A SYNC value here is an address byte; no resynchronisation.
        if (i_rx_valid)   state_next = S_DATA;
        else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_DATA: begin
        if (i_rx_valid)   state_next = S_CHK;
        else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_CHK: begin
        if (i_rx_valid) begin
          state_next = S_RESP;
          cmd_ok     = chk_ok;
          cmd_bad    = !chk_ok;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_RESP: begin
        // Bytes arriving while a response is outstanding are discarded.
        drop = i_rx_valid;
        if (i_tx_ready) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // The three error sources live in mutually exclusive states, but they are
  // merged into one event so a cycle can never add more than one.
  assign err_evt = cmd_bad | drop | timeout;

  // ---------------------------------------------------------------------------
  // State register, command capture and timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      tmo_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples pre-edge values, independent of statement order.
      state <= state_next;
      if (i_rx_valid && (state == S_ADDR)) addr_q <= i_rx_byte;
      if (i_rx_valid && (state == S_DATA)) data_q <= i_rx_byte;

      if (i_rx_valid || timeout || (state == S_IDLE) || (state == S_RESP))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Staged / active register file with frame-synchronous commit
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: only four bytes each, and the outputs must read 0 straight out
      // of reset, so these arrays are reset like ordinary flops rather than
      // being left as uninitialised storage.
      for (int i = 0; i < 4; i++) begin
        staged[i] <= 8'h00;
        active[i] <= 8'h00;
      end
      pending <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // Commit reads staged[] before this edge's write lands, so a write
        // coinciding with the strobe waits for the next strobe.
        if (i_frame_strobe && pending[i]) active[i] <= staged[i];

        if (cmd_ok && (wr_idx == 2'(i))) begin
          staged[i]  <= data_q;
          pending[i] <= 1'b1;
        end else if (i_frame_strobe) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response byte and error counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_byte   <= 8'h00;
      err_count <= 8'h00;
    end else begin
      if (cmd_ok)       tx_byte <= ACK_BYTE;
      else if (cmd_bad) tx_byte <= NAK_BYTE;

      if (err_evt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign o_tx_valid    = (state == S_RESP);
  assign o_tx_byte     = tx_byte;
  assign o_cfg_pattern = active[0];
  assign o_cfg_fg      = active[1];
  assign o_cfg_bg      = active[2];
  assign o_cfg_ctrl    = active[3];
  assign o_pending     = pending;
  assign o_err_count   = err_count;

endmodule

// File: tb/tb_video_cmd_controller.sv
// -----------------------------------------------------------------------------
// tb_video_cmd_controller
//
// Self-checking bench for video_cmd_controller. A transaction-level reference
// model (bytes collected per command, a response-outstanding flag, staged /
// active / pending arrays) is stepped once per clock and every DUT output is
// compared against it after each edge. Directed scenarios cover the documented
// cases; a randomized command stream with random gaps, back-pressure and frame
// strobes covers the rest.
// -----------------------------------------------------------------------------
module tb_video_cmd_controller;

  localparam int         T    = 25000;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_strobe;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] cfg_pattern, cfg_fg, cfg_bg, cfg_ctrl;
  logic [3:0] pending;
  logic [7:0] err_count;

  always #20 clk = ~clk;

  video_cmd_controller dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_rx_byte      (rx_byte),
    .i_rx_valid     (rx_valid),
    .i_frame_strobe (frame_strobe),
    .o_tx_byte      (tx_byte),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .o_cfg_pattern  (cfg_pattern),
    .o_cfg_fg       (cfg_fg),
    .o_cfg_bg       (cfg_bg),
    .o_cfg_ctrl     (cfg_ctrl),
    .o_pending      (pending),
    .o_err_count    (err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] m_stage [4];
  logic [7:0] m_act   [4];
  logic [3:0] m_pend;
  int         m_len;      // command bytes collected so far (0 = hunting SYNC)
  logic [7:0] m_addr, m_data;
  bit         m_resp;     // response outstanding
  logic [7:0] m_txb;
  int         m_idle;     // clocks since last byte inside a command
  int         m_err;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_stage[i] = 8'h00;
      m_act[i]   = 8'h00;
    end
    m_pend = 4'b0; m_len = 0; m_addr = 0; m_data = 0;
    m_resp = 0; m_txb = 8'h00; m_idle = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit rv, input logic [7:0] rb,
                                     input bit fs, input bit rdy);
    bit         wr = 0;
    int         wa = 0;
    logic [7:0] wd = 0;
    bit         e  = 0;
    if (m_resp) begin
      if (rv)  e = 1;
      if (rdy) m_resp = 0;
      m_idle = 0;
    end else if (m_len == 0) begin
      if (rv && rb == SYNC) m_len = 1;
      m_idle = 0;
    end else if (rv) begin
      m_idle = 0;
      if (m_len == 1) begin
        m_addr = rb; m_len = 2;
      end else if (m_len == 2) begin
        m_data = rb; m_len = 3;
      end else begin
        m_len  = 0;
        m_resp = 1;
        if (rb == (m_addr ^ m_data) && m_addr < 4) begin
          wr = 1; wa = int'(m_addr); wd = m_data; m_txb = ACK;
        end else begin
          m_txb = NAK; e = 1;
        end
      end
    end else if (m_idle == T - 1) begin
      m_len = 0; m_idle = 0; e = 1;
    end else begin
      m_idle++;
    end
    // Commit first with the pre-write staged values, then apply the write.
    if (fs) begin
      for (int i = 0; i < 4; i++) if (m_pend[i]) m_act[i] = m_stage[i];
      m_pend = 4'b0;
    end
    if (wr) begin
      m_stage[wa] = wd;
      m_pend[wa]  = 1'b1;
    end
    if (e && m_err < 255) m_err++;
  endfunction

  task automatic check_all();
    check("tx_valid", tx_valid,    m_resp);
    check("tx_byte",  tx_byte,     m_txb);
    check("pattern",  cfg_pattern, m_act[0]);
    check("fg",       cfg_fg,      m_act[1]);
    check("bg",       cfg_bg,      m_act[2]);
    check("ctrl",     cfg_ctrl,    m_act[3]);
    check("pending",  pending,     m_pend);
    check("err",      err_count,   m_err[7:0]);
  endtask

  // One clock: drive on the falling edge, step the model at the rising edge,
  // compare 1 time unit later.
  task automatic cycle(input bit rv, input logic [7:0] rb, input bit fs, input bit rdy);
    @(negedge clk);
    rx_valid     = rv;
    rx_byte      = rb;
    frame_strobe = fs;
    tx_ready     = rdy;
    @(posedge clk);
    model_step(rv, rb, fs, rdy);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b1);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send(SYNC); send(a); send(d); send(c);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0, rdy);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; rx_valid = 0; rx_byte = 0; frame_strobe = 0; tx_ready = 0;
    model_reset();
    #50;
    check_all();
    check("reset_err", err_count, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Valid write to reg 0, visible only after the frame strobe.
    send4(8'h00, 8'h03, 8'h03);
    check("tc1_ack", {tx_valid, tx_byte}, {1'b1, ACK});
    check("tc1_pend", pending, 4'b0001);
    check("tc1_pat_pre", cfg_pattern, 8'h00);
    idle(1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("tc1_pat_post", cfg_pattern, 8'h03);
    check("tc1_pend_post", pending, 4'b0000);

    // Bad checksum.
    send4(8'h01, 8'hE0, 8'h00);
    check("tc2_nak", tx_byte, NAK);
    check("tc2_err", err_count, 8'd1);
    check("tc2_fg", cfg_fg, 8'h00);
    idle(1, 1'b1);

    // Address out of range with a correct checksum.
    send4(8'h07, 8'h11, 8'h16);
    check("tc3_nak", tx_byte, NAK);
    check("tc3_err", err_count, 8'd2);
    check("tc3_pend", pending, 4'b0000);
    idle(1, 1'b1);

    // Timeout inside a command, then a clean command.
    send(SYNC); send(8'h02);
    idle(T - 1, 1'b1);
    check("tc4_no_to_yet", err_count, 8'd2);
    idle(1, 1'b1);
    check("tc4_err", err_count, 8'd3);
    check("tc4_no_tx", tx_valid, 1'b0);
    send4(8'h02, 8'h1C, 8'h1E);
    check("tc4_ack", tx_byte, ACK);
    check("tc4_pend", pending, 4'b0100);
    idle(1, 1'b1);

    // Back-pressure on the response with bytes dropped meanwhile.
    send4(8'h03, 8'h44, 8'h47);
    idle(40, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    idle(30, 1'b0);
    cycle(1'b1, SYNC, 1'b0, 1'b0);
    idle(28, 1'b0);
    check("tc5_hold", {tx_valid, tx_byte}, {1'b1, ACK});
    check("tc5_err", err_count, 8'd5);
    idle(1, 1'b1);
    check("tc5_released", tx_valid, 1'b0);

    // CHK byte coincident with the frame strobe.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    send4(8'h00, 8'h05, 8'h05);
    idle(1, 1'b1);
    send(SYNC); send(8'h00); send(8'h09);
    cycle(1'b1, 8'h09, 1'b1, 1'b1);
    check("tc6_pat", cfg_pattern, 8'h05);
    check("tc6_pend", pending[0], 1'b1);
    idle(1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("tc6_pat_next", cfg_pattern, 8'h09);

    // Randomized command stream.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] q [$];
      logic [7:0] a, d, c;
      if ($urandom_range(0, 7) == 0) q.push_back(8'($urandom));
      a = 8'($urandom_range(0, 4));
      d = 8'($urandom);
      c = a ^ d;
      if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
      q.push_back(SYNC); q.push_back(a); q.push_back(d); q.push_back(c);
      foreach (q[k]) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++)
          cycle(1'b0, 8'($urandom), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) < 7));
        cycle(1'b1, q[k], ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
      end
    end
    idle(4, 1'b1);

    // Error counter saturation via dropped bytes during a held response.
    send4(8'h01, 8'h00, 8'h01);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    check("sat_err", err_count, 8'hFF);
    idle(1, 1'b1);

    // Asynchronous reset while a response is outstanding.
    send4(8'h02, 8'h33, 8'h31);
    idle(3, 1'b0);
    @(negedge clk);
    tx_ready = 1'b0;
    #5 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_err", err_count, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    send4(8'h01, 8'h12, 8'h13);
    check("post_rst_ack", tx_byte, ACK);
    idle(1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
